// File: rtl/axi_cache_top.sv
// AXI4 memory-mapped slave backing store: independent write and read FSMs
// serving INCR/FIXED bursts from a word-organised RAM with byte strobes.
module axi_cache_top #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  input  logic                        M_AXI_AWVALID,
  output logic                        M_AXI_AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  input  logic [1:0]                  M_AXI_AWBURST,
  input  logic [2:0]                  M_AXI_AWSIZE,
  input  logic [7:0]                  M_AXI_AWLEN,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                        M_AXI_WVALID,
  output logic                        M_AXI_WREADY,
  input  logic                        M_AXI_WLAST,
  output logic [1:0]                  M_AXI_BRESP,
  output logic                        M_AXI_BVALID,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic                        M_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  input  logic                        M_AXI_ARVALID,
  output logic                        M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  input  logic [1:0]                  M_AXI_ARBURST,
  input  logic [2:0]                  M_AXI_ARSIZE,
  input  logic [7:0]                  M_AXI_ARLEN,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  output logic [1:0]                  M_AXI_RRESP,
  output logic                        M_AXI_RVALID,
  output logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
  output logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RREADY
);

  localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(DATA_BYTES);
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef logic [IDX_W-1:0]          idx_t;
  typedef logic [AXI_DATA_WIDTH-1:0] word_t;
  typedef logic [DATA_BYTES-1:0]     strb_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic idx_t addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  // WRAP and the reserved encoding advance like INCR.
  function automatic idx_t next_idx(input idx_t i, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? i : i + idx_t'(1);
  endfunction

  function automatic word_t merge(input word_t old_w, input word_t new_w, input strb_t strb);
    word_t res;
    res = old_w;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  word_t mem_q [MEM_DEPTH];

  w_state_e                  w_state_q;
  logic                      awready_q, wready_q, bvalid_q, w_err_q;
  logic [1:0]                bresp_q, w_burst_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q, w_id_q;
  idx_t                      w_idx_q;
  logic [7:0]                w_len_q, w_beat_q;

  r_state_e                  r_state_q;
  logic                      arready_q, rvalid_q, rlast_q;
  logic [1:0]                r_burst_q;
  logic [AXI_ID_WIDTH-1:0]   rid_q;
  idx_t                      r_idx_q;
  logic [7:0]                r_len_q, r_beat_q;
  word_t                     rdata_q;

  logic  w_fire, w_last_beat, w_last_err, ar_fire, r_fire;
  idx_t  ar_idx_d, r_next_idx_d;
  word_t ar_word_d, r_next_word_d;

  assign w_fire      = M_AXI_WVALID & wready_q;
  assign w_last_beat = (w_beat_q == w_len_q);
  assign w_last_err  = (M_AXI_WLAST != w_last_beat);
  assign ar_fire     = M_AXI_ARVALID & arready_q;
  assign r_fire      = rvalid_q & M_AXI_RREADY;

  // Read words are captured one cycle before they are presented, so a write
  // landing in that capture cycle is forwarded to keep it visible.
  always_comb begin
    ar_idx_d      = addr_idx(M_AXI_ARADDR);
    r_next_idx_d  = next_idx(r_idx_q, r_burst_q);
    ar_word_d     = mem_q[ar_idx_d];
    r_next_word_d = mem_q[r_next_idx_d];
    if (w_fire && (w_idx_q == ar_idx_d))
      ar_word_d = merge(ar_word_d, M_AXI_WDATA, M_AXI_WSTRB);
    if (w_fire && (w_idx_q == r_next_idx_d))
      r_next_word_d = merge(r_next_word_d, M_AXI_WDATA, M_AXI_WSTRB);
  end

  always_ff @(posedge clk) begin
    if (w_fire) mem_q[w_idx_q] <= merge(mem_q[w_idx_q], M_AXI_WDATA, M_AXI_WSTRB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      w_err_q   <= 1'b0;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awready_q && M_AXI_AWVALID) begin
            w_idx_q   <= addr_idx(M_AXI_AWADDR);
            w_id_q    <= M_AXI_AWID;
            w_len_q   <= M_AXI_AWLEN;
            w_burst_q <= M_AXI_AWBURST;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last_err) w_err_q <= 1'b1;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= (w_err_q || w_last_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              w_beat_q <= w_beat_q + 8'd1;
              w_idx_q  <= next_idx(w_idx_q, w_burst_q);
            end
          end
        end
        W_RESP: begin
          if (M_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            r_idx_q   <= ar_idx_d;
            r_len_q   <= M_AXI_ARLEN;
            r_burst_q <= M_AXI_ARBURST;
            r_beat_q  <= '0;
            rid_q     <= M_AXI_ARID;
            rdata_q   <= ar_word_d;
            rlast_q   <= (M_AXI_ARLEN == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q  <= r_next_idx_d;
              r_beat_q <= r_beat_q + 8'd1;
              rdata_q  <= r_next_word_d;
              rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign M_AXI_AWREADY = awready_q;
  assign M_AXI_WREADY  = wready_q;
  assign M_AXI_BVALID  = bvalid_q;
  assign M_AXI_BRESP   = bresp_q;
  assign M_AXI_BID     = bid_q;
  assign M_AXI_ARREADY = arready_q;
  assign M_AXI_RVALID  = rvalid_q;
  assign M_AXI_RDATA   = rdata_q;
  assign M_AXI_RID     = rid_q;
  assign M_AXI_RLAST   = rlast_q;
  assign M_AXI_RRESP   = RESP_OKAY;

  // Beat size and the address bits outside the word index play no part.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWADDR, M_AXI_ARADDR};

endmodule

// File: tb/tb_axi_cache_top.sv
// Directed bench for axi_cache_top: vector table of single-beat write/read
// pairs plus hand sequences for bursts, stalls, WLAST errors and reset.
module tb_axi_cache_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, araddr;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  awid, arid, bid, rid;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen, wstrb;
  logic [63:0] wdata, rdata;

  always #5 clk = ~clk;

  axi_cache_top dut (
    .clk(clk), .rst_n(rst_n),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst), .M_AXI_AWSIZE(awsize), .M_AXI_AWLEN(awlen),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_WLAST(wlast), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BID(bid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst), .M_AXI_ARSIZE(arsize), .M_AXI_ARLEN(arlen),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RID(rid),
    .M_AXI_RLAST(rlast), .M_AXI_RREADY(rready)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic        wl [8];
  logic [63:0] rd [8];
  logic        rl [8];

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  wid;
    logic [63:0] wdat;
    logic [7:0]  wstb;
    logic [31:0] raddr;
    logic [3:0]  rid;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits on a negedge for the selected READY/VALID; n = extra cycles waited.
  task automatic wait_sig(input int which, output int n);
    logic s;
    n = 0;
    forever begin
      @(negedge clk);
      case (which)
        0: s = awready;
        1: s = wready;
        2: s = bvalid;
        3: s = arready;
        default: s = rvalid;
      endcase
      if (s === 1'b1) break;
      n++;
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL timeout_sig%0d: got no handshake expected one within 100 cycles", which);
        break;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, output logic [1:0] br, output logic [3:0] bi);
    int n;
    awaddr = addr; awid = id; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    wait_sig(0, n);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      wait_sig(1, n);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    wait_sig(2, n);
    br = bresp; bi = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, output int lat, output logic [3:0] ri);
    int n;
    rready = 1'b1;
    araddr = addr; arid = id; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
    wait_sig(3, n);
    @(posedge clk); #1 arvalid = 1'b0;
    lat = 0;
    for (int i = 0; i <= len; i++) begin
      wait_sig(4, n);
      if (i == 0) lat = n;
      rd[i] = rdata; rl[i] = rlast; ri = rid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected one before 500000 time units");
    $fatal(1);
  end

  initial begin
    logic [1:0] br;
    logic [3:0] bi, ri;
    int lat, n;
    logic any_b;

    vt[0] = '{32'h0000_0000, 4'h3, 64'h1122334455667788, 8'hFF, 32'h8000_0000, 4'h5, 64'h1122334455667788};
    vt[1] = '{32'h0000_0008, 4'h1, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 32'h0000_0008, 4'h2, 64'hAAAAAAAAAAAAAAAA};
    vt[2] = '{32'h0000_000C, 4'h7, 64'h0000000055555555, 8'h0F, 32'h0000_0008, 4'h4, 64'hAAAAAAAA55555555};
    vt[3] = '{32'h0000_2008, 4'hF, 64'hFFFF000000000000, 8'hC0, 32'h0000_000C, 4'h6, 64'hFFFFAAAA55555555};
    vt[4] = '{32'h0000_1FF8, 4'h0, 64'h0123456789ABCDEF, 8'hFF, 32'hFFFF_FFF8, 4'h9, 64'h0123456789ABCDEF};
    vt[5] = '{32'h0000_1FF8, 4'hE, 64'hDEADDEADDEADDEAD, 8'h00, 32'h0000_1FF8, 4'hB, 64'h0123456789ABCDEF};

    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; awid = '0; awburst = 2'b01; awsize = 3'd3; awlen = '0;
    wdata = '0; wstrb = '0; wvalid = 0; wlast = 0; bready = 0;
    araddr = '0; arvalid = 0; arid = '0; arburst = 2'b01; arsize = 3'd3; arlen = '0; rready = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_valids", {bvalid, rvalid, wready}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {bid, rid, bresp, rresp}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready_before_edge", awready, 0);
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      wd[0] = vt[i].wdat; ws[0] = vt[i].wstb; wl[0] = 1'b1;
      do_write(vt[i].waddr, vt[i].wid, 0, 2'b01, br, bi);
      chk($sformatf("vec%0d_bresp", i), br, 2'b00);
      chk($sformatf("vec%0d_bid", i), bi, vt[i].wid);
      do_read(vt[i].raddr, vt[i].rid, 0, 2'b01, lat, ri);
      chk($sformatf("vec%0d_rdata", i), rd[0], vt[i].exp);
      chk($sformatf("vec%0d_rid", i), ri, vt[i].rid);
      chk($sformatf("vec%0d_rlast", i), rl[0], 1);
      chk($sformatf("vec%0d_rvalid_latency", i), lat, 0);
    end

    // INCR burst with a partial strobe on beat 2 over pre-existing data
    wd[0] = 64'hCAFEBABEDEADBEEF; ws[0] = 8'hFF; wl[0] = 1'b1;
    do_write(32'h30, 4'h1, 0, 2'b01, br, bi);
    wd[0] = 64'd0; wd[1] = 64'd1; wd[2] = 64'd2; wd[3] = 64'd3;
    ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'h0F; ws[3] = 8'hFF;
    wl[0] = 0; wl[1] = 0; wl[2] = 0; wl[3] = 1;
    do_write(32'h20, 4'h2, 3, 2'b01, br, bi);
    chk("incr_bresp", br, 2'b00);
    chk("incr_bid", bi, 4'h2);
    do_read(32'h20, 4'h6, 3, 2'b01, lat, ri);
    chk("incr_rd0", rd[0], 64'd0);
    chk("incr_rd1", rd[1], 64'd1);
    chk("incr_rd2", rd[2], 64'hCAFEBABE00000002);
    chk("incr_rd3", rd[3], 64'd3);
    chk("incr_rlast", {rl[0], rl[1], rl[2], rl[3]}, 4'b0001);

    // RREADY stall keeps beat 0 stable
    rready = 1'b0;
    araddr = 32'h20; arid = 4'hA; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1;
    wait_sig(3, n);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    chk("stall_rvalid", rvalid, 1);
    chk("stall_rdata0", rdata, 64'd0);
    chk("stall_rlast0", rlast, 0);
    @(negedge clk);
    chk("stall_hold_rdata", rdata, 64'd0);
    chk("stall_hold_rvalid", rvalid, 1);
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk);
    chk("stall_hold2_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_rdata1", rdata, 64'd1);
    chk("stall_rlast1", rlast, 1);
    chk("stall_rid", rid, 4'hA);
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("stall_done_rvalid", rvalid, 0);
    @(posedge clk); #1;

    // Early WLAST: SLVERR, but both beats still land
    wd[0] = 64'h11; wd[1] = 64'h22; ws[0] = 8'hFF; ws[1] = 8'hFF; wl[0] = 1; wl[1] = 1;
    do_write(32'h40, 4'h8, 1, 2'b01, br, bi);
    chk("wlast_err_bresp", br, 2'b10);
    chk("wlast_err_bid", bi, 4'h8);
    do_read(32'h40, 4'h1, 1, 2'b01, lat, ri);
    chk("wlast_err_rd0", rd[0], 64'h11);
    chk("wlast_err_rd1", rd[1], 64'h22);
    wd[0] = 64'h33; ws[0] = 8'hFF; wl[0] = 1;
    do_write(32'h40, 4'h9, 0, 2'b01, br, bi);
    chk("wlast_err_cleared", br, 2'b00);

    // FIXED burst keeps hitting one word
    wd[0] = 64'd10; wd[1] = 64'd11; wd[2] = 64'd12;
    ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF; wl[0] = 0; wl[1] = 0; wl[2] = 1;
    do_write(32'h60, 4'h3, 2, 2'b00, br, bi);
    chk("fixed_bresp", br, 2'b00);
    do_read(32'h60, 4'h3, 1, 2'b00, lat, ri);
    chk("fixed_rd0", rd[0], 64'd12);
    chk("fixed_rd1", rd[1], 64'd12);
    do_read(32'h40, 4'h3, 0, 2'b00, lat, ri);
    chk("fixed_neighbour", rd[0], 64'h33);

    // INCR wraps from the last word to word 0
    wd[0] = 64'hA1; wd[1] = 64'hA2; ws[0] = 8'hFF; ws[1] = 8'hFF; wl[0] = 0; wl[1] = 1;
    do_write(32'h1FF8, 4'h4, 1, 2'b01, br, bi);
    do_read(32'h7FF8, 4'h4, 1, 2'b01, lat, ri);
    chk("wrap_rd0", rd[0], 64'hA1);
    chk("wrap_rd1", rd[1], 64'hA2);

    // Reset during the data phase aborts without a response
    awaddr = 32'h80; awid = 4'hC; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    wait_sig(0, n);
    @(posedge clk); #1 awvalid = 1'b0;
    wdata = 64'h55; wstrb = 8'hFF; wlast = 0; wvalid = 1'b1;
    wait_sig(1, n);
    @(posedge clk); #1 wvalid = 1'b0;
    rst_n = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    any_b = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_b = any_b | bvalid;
    end
    chk("midrst_no_bvalid", any_b, 0);
    @(posedge clk); #1 bready = 1'b0;
    wd[0] = 64'h7777; ws[0] = 8'hFF; wl[0] = 1;
    do_write(32'h88, 4'h5, 0, 2'b01, br, bi);
    chk("midrst_new_bresp", br, 2'b00);
    chk("midrst_new_bid", bi, 4'h5);
    do_read(32'h88, 4'h2, 0, 2'b01, lat, ri);
    chk("midrst_new_rdata", rd[0], 64'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
